floo_axis_flit_unpacker: RTL

FLOO_AXIS_FLIT_UNPACKER -- requirements
Module: floo_axis_flit_unpacker

---
 rtl/floo_axis_flit_unpacker.sv | 133 +++++++++++++
 1 files changed

// File: rtl/floo_axis_flit_unpacker.sv
// Splits a packed AXIS beat into independent req/rsp flit streams, each
// buffered by a small registered FIFO, and counts beats carrying no flit.

module floo_axis_flit_fifo #(
  parameter int Width = 64,
  parameter int Depth = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  output logic                     valid,
  output logic [Width-1:0]         head,
  output logic [$clog2(Depth):0]   usage,
  output logic                     full
);
  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      usage_reg;

  // Depth is a power of two, so natural pointer overflow gives the wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      usage_reg  <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr_reg] <= push_data;
        wr_ptr_reg      <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        usage_reg <= usage_reg + 1'b1;
      end else if (!push && pop) begin
        usage_reg <= usage_reg - 1'b1;
      end
    end
  end

  assign valid = (usage_reg != '0);
  assign head  = mem[rd_ptr_reg];
  assign usage = usage_reg;
  assign full  = (usage_reg == FULL_LEVEL);
endmodule

module floo_axis_flit_unpacker #(
  parameter int ReqWidth = 64,
  parameter int RspWidth = 64,
  parameter int Depth    = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         axis_tvalid_i,
  output logic                         axis_tready_o,
  input  logic [ReqWidth+RspWidth+1:0] axis_tdata_i,
  output logic                         req_valid_o,
  output logic [ReqWidth-1:0]          req_data_o,
  input  logic                         req_ready_i,
  output logic                         rsp_valid_o,
  output logic [RspWidth-1:0]          rsp_data_o,
  input  logic                         rsp_ready_i,
  output logic [$clog2(Depth):0]       req_usage_o,
  output logic [$clog2(Depth):0]       rsp_usage_o,
  output logic [15:0]                  empty_beats_o
);
  logic [ReqWidth-1:0] beat_req_data;
  logic                beat_req_valid;
  logic [RspWidth-1:0] beat_rsp_data;
  logic                beat_rsp_valid;
  logic                accept;
  logic                req_full;
  logic                rsp_full;
  logic                req_pop;
  logic                rsp_pop;
  logic [15:0]         empty_beats_reg;

  assign beat_req_data  = axis_tdata_i[ReqWidth+RspWidth+1 -: ReqWidth];
  assign beat_req_valid = axis_tdata_i[RspWidth+1];
  assign beat_rsp_data  = axis_tdata_i[RspWidth:1];
  assign beat_rsp_valid = axis_tdata_i[0];

  // Full is checked before any same-cycle pop, so a freed slot opens next cycle.
  assign axis_tready_o = !rst_i && !req_full && !rsp_full;
  assign accept        = axis_tvalid_i && axis_tready_o;
  assign req_pop       = req_valid_o && req_ready_i;
  assign rsp_pop       = rsp_valid_o && rsp_ready_i;

  floo_axis_flit_fifo #(.Width(ReqWidth), .Depth(Depth)) u_req_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (accept && beat_req_valid),
    .push_data (beat_req_data),
    .pop       (req_pop),
    .valid     (req_valid_o),
    .head      (req_data_o),
    .usage     (req_usage_o),
    .full      (req_full)
  );

  floo_axis_flit_fifo #(.Width(RspWidth), .Depth(Depth)) u_rsp_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (accept && beat_rsp_valid),
    .push_data (beat_rsp_data),
    .pop       (rsp_pop),
    .valid     (rsp_valid_o),
    .head      (rsp_data_o),
    .usage     (rsp_usage_o),
    .full      (rsp_full)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      empty_beats_reg <= '0;
    end else if (accept && !beat_req_valid && !beat_rsp_valid &&
                 empty_beats_reg != 16'hFFFF) begin
      empty_beats_reg <= empty_beats_reg + 16'd1;
    end
  end

  assign empty_beats_o = empty_beats_reg;
endmodule
